// File: rtl/seven_segment_time_decoder_if.sv
// Bundle between the elapsed-time counter and the HEX digit driver.
//   i_value    : seconds count from the timer (0..63)
//   i_paused   : timer paused, digits blink
//   i_blank    : force both digits dark
//   o_seg_tens : tens digit, {g,f,e,d,c,b,a}, active-low
//   o_seg_ones : ones digit, {g,f,e,d,c,b,a}, active-low
//   o_busy     : binary->BCD conversion in progress
// master = timer side (drives the value), slave = the decoder.
interface seven_segment_time_decoder_if;
    logic [5:0] i_value;
    logic       i_paused;
    logic       i_blank;
    logic [6:0] o_seg_tens;
    logic [6:0] o_seg_ones;
    logic       o_busy;

    modport master (
        output i_value, i_paused, i_blank,
        input  o_seg_tens, o_seg_ones, o_busy
    );

    modport slave (
        input  i_value, i_paused, i_blank,
        output o_seg_tens, o_seg_ones, o_busy
    );
endinterface

// File: rtl/seven_segment_time_decoder.sv
// Drives two 7-segment digits (tens, ones) from the 6-bit seconds value.
// Binary->BCD conversion is sequential shift-add-3, one bit per clock, and is
// only started when the value differs from the last converted one. Digits blink
// while the timer is paused and can be forced dark.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous, active-low reset
//   bus   : seven_segment_time_decoder_if.slave (value/pause/blank in,
//           segment digits and busy out)
// Parameters:
//   BLINK_CYCLES : clk cycles per blink half-period (>= 1)
//   LZ_SUPPRESS  : 1 blanks the tens digit when it is 0
module seven_segment_time_decoder #(
    parameter int BLINK_CYCLES = 6000000,
    parameter bit LZ_SUPPRESS  = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    seven_segment_time_decoder_if.slave   bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam int CNT_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_CYCLES - 1);

    localparam logic [6:0] SEG_DARK = 7'h7F;
    localparam logic [6:0] SEG_ZERO = 7'b1000000;

    logic [1:0]       state_reg;
    logic [5:0]       last_reg;
    logic [5:0]       cap_reg;
    // [13:10] tens BCD, [9:6] ones BCD, [5:0] binary bits still to shift in
    logic [13:0]      shift_reg;
    logic [13:0]      shift_adj;
    logic [2:0]       bit_cnt_reg;
    logic [3:0]       tens_reg;
    logic [3:0]       ones_reg;
    logic             blink_on_reg;
    logic [CNT_W-1:0] blink_cnt_reg;
    logic [6:0]       seg_tens_reg;
    logic [6:0]       seg_ones_reg;
    logic [6:0]       seg_tens_next;
    logic [6:0]       seg_ones_next;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Add-3 correction on each BCD nibble before the shift.
    always_comb begin
        shift_adj = shift_reg;
        if (shift_reg[13:10] >= 4'd5) shift_adj[13:10] = shift_reg[13:10] + 4'd3;
        if (shift_reg[9:6]   >= 4'd5) shift_adj[9:6]   = shift_reg[9:6]   + 4'd3;
    end

    // Conversion FSM. A change arriving mid-conversion is picked up on the
    // next IDLE compare against last_reg, so the display always settles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            last_reg    <= 6'd0;
            cap_reg     <= 6'd0;
            shift_reg   <= 14'd0;
            bit_cnt_reg <= 3'd0;
            tens_reg    <= 4'd0;
            ones_reg    <= 4'd0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (bus.i_value != last_reg) begin
                        shift_reg   <= {8'd0, bus.i_value};
                        cap_reg     <= bus.i_value;
                        bit_cnt_reg <= 3'd0;
                        state_reg   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    shift_reg   <= {shift_adj[12:0], 1'b0};
                    bit_cnt_reg <= bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd5) state_reg <= S_DONE;
                end
                S_DONE: begin
                    tens_reg  <= shift_reg[13:10];
                    ones_reg  <= shift_reg[9:6];
                    last_reg  <= cap_reg;
                    state_reg <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    // Blink phase: toggles every BLINK_CYCLES clocks while paused, forced lit otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_reg <= '0;
            blink_on_reg  <= 1'b1;
        end else if (!bus.i_paused) begin
            blink_cnt_reg <= '0;
            blink_on_reg  <= 1'b1;
        end else if (blink_cnt_reg == CNT_MAX) begin
            blink_cnt_reg <= '0;
            blink_on_reg  <= ~blink_on_reg;
        end else begin
            blink_cnt_reg <= blink_cnt_reg + CNT_W'(1);
        end
    end

    // Per-digit decode: index 0 = ones, 1 = tens.
    logic [3:0] digit     [2];
    logic [6:0] digit_seg [2];
    assign digit[0] = ones_reg;
    assign digit[1] = tens_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_decode
            assign digit_seg[gi] = seg_decode(digit[gi]);
        end
    endgenerate

    always_comb begin
        seg_tens_next = digit_seg[1];
        seg_ones_next = digit_seg[0];
        if (bus.i_blank || !blink_on_reg) begin
            seg_tens_next = SEG_DARK;
            seg_ones_next = SEG_DARK;
        end else if (LZ_SUPPRESS && (tens_reg == 4'd0)) begin
            seg_tens_next = SEG_DARK;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_tens_reg <= LZ_SUPPRESS ? SEG_DARK : SEG_ZERO;
            seg_ones_reg <= SEG_ZERO;
        end else begin
            seg_tens_reg <= seg_tens_next;
            seg_ones_reg <= seg_ones_next;
        end
    end

    assign bus.o_seg_tens = seg_tens_reg;
    assign bus.o_seg_ones = seg_ones_reg;
    assign bus.o_busy     = (state_reg != S_IDLE);

endmodule

// File: tb/tb_seven_segment_time_decoder.sv
// Self-checking bench for seven_segment_time_decoder (BLINK_CYCLES=4, no
// leading-zero suppression). Expected digit pairs are pushed to a queue when a
// new value is driven and popped when the conversion result appears.
module tb_seven_segment_time_decoder;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    seven_segment_time_decoder_if bus ();

    seven_segment_time_decoder #(
        .BLINK_CYCLES (4),
        .LZ_SUPPRESS  (1'b0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    localparam logic [13:0] DARK_PAIR = 14'h3FFF;
    localparam logic [13:0] ZERO_PAIR = {7'b1000000, 7'b1000000};

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [13:0] sb [$];
    logic [13:0] shown;
    int          bc;

    function automatic logic [6:0] ref_seg(input int d);
        case (d)
            0:       return 7'b1000000;
            1:       return 7'b1111001;
            2:       return 7'b0100100;
            3:       return 7'b0110000;
            4:       return 7'b0011001;
            5:       return 7'b0010010;
            6:       return 7'b0000010;
            7:       return 7'b1111000;
            8:       return 7'b0000000;
            9:       return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [13:0] ref_pair(input int v);
        return {ref_seg(v / 10), ref_seg(v % 10)};
    endfunction

    task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [13:0] seg_pair();
        return {bus.o_seg_tens, bus.o_seg_ones};
    endfunction

    task automatic set_value(input int v);
        @(negedge clk);
        bus.i_value = 6'(v);
        sb.push_back(ref_pair(v));
    endtask

    // Waits for the running conversion to finish, then one more edge for the
    // output register, and compares against the oldest queued expectation.
    task automatic wait_result(input string tag, input bit blanked, output int busy_cycles);
        logic [13:0] e;
        bit          done;
        done        = 1'b0;
        busy_cycles = 0;
        @(negedge clk);
        if (!blanked) check_eq({tag, "_hold"}, 16'(seg_pair()), 16'(shown));
        for (int i = 0; i < 40; i++) begin
            if (!bus.o_busy) begin
                done = 1'b1;
                break;
            end
            busy_cycles++;
            @(negedge clk);
        end
        check_eq({tag, "_done"}, 16'(done), 16'd1);
        @(negedge clk);
        check_eq({tag, "_sb"}, 16'(sb.size() > 0), 16'd1);
        if (sb.size() == 0) return;
        e     = sb.pop_front();
        shown = e;
        if (blanked) check_eq({tag, "_seg"}, 16'(seg_pair()), 16'(DARK_PAIR));
        else         check_eq({tag, "_seg"}, 16'(seg_pair()), 16'(e));
        $display("conv %s: busy=%0d tens=%b ones=%b", tag, busy_cycles, bus.o_seg_tens, bus.o_seg_ones);
    endtask

    initial begin
        bus.i_value  = 6'd0;
        bus.i_paused = 1'b0;
        bus.i_blank  = 1'b0;
        rst_n        = 1'b0;
        shown        = ZERO_PAIR;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_seg", 16'(seg_pair()), 16'(ZERO_PAIR));
        check_eq("rst_busy", 16'(bus.o_busy), 16'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("idle0_busy", 16'(bus.o_busy), 16'd0);
        check_eq("idle0_seg", 16'(seg_pair()), 16'(ZERO_PAIR));

        // Basic conversions including the 60..63 range
        set_value(37); wait_result("v37", 1'b0, bc); check_eq("v37_busy", 16'(bc), 16'd7);
        set_value(59); wait_result("v59", 1'b0, bc); check_eq("v59_busy", 16'(bc), 16'd7);
        set_value(0);  wait_result("v00", 1'b0, bc); check_eq("v00_busy", 16'(bc), 16'd7);
        set_value(63); wait_result("v63", 1'b0, bc); check_eq("v63_busy", 16'(bc), 16'd7);
        set_value(60); wait_result("v60", 1'b0, bc);

        // Value change mid-conversion: 12 shown first, then 45
        set_value(12);
        @(negedge clk);
        set_value(45);
        wait_result("v12", 1'b0, bc);
        check_eq("v45_restart", 16'(bus.o_busy), 16'd1);
        wait_result("v45", 1'b0, bc);

        // Unchanged value starts nothing
        repeat (3) @(negedge clk);
        check_eq("nochange_busy", 16'(bus.o_busy), 16'd0);

        // Blink: 4 cycles lit, 4 dark, ...
        @(negedge clk);
        bus.i_paused = 1'b1;
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk);
            if (((k - 1) / 4) % 2 == 1) check_eq("blink_dark", 16'(seg_pair()), 16'(DARK_PAIR));
            else                        check_eq("blink_lit",  16'(seg_pair()), 16'(shown));
        end
        bus.i_paused = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("unpause_lit", 16'(seg_pair()), 16'(shown));

        // Forced blank
        bus.i_blank = 1'b1;
        @(negedge clk);
        check_eq("blank_dark", 16'(seg_pair()), 16'(DARK_PAIR));
        bus.i_blank = 1'b0;
        @(negedge clk);
        check_eq("unblank_lit", 16'(seg_pair()), 16'(shown));

        // Conversion keeps running while blanked
        bus.i_blank = 1'b1;
        set_value(8);
        wait_result("v08_blanked", 1'b1, bc);
        check_eq("v08_busy", 16'(bc), 16'd7);
        bus.i_blank = 1'b0;
        @(negedge clk);
        check_eq("v08_unblank", 16'(seg_pair()), 16'(shown));

        // Reset in the middle of a conversion, then reconversion
        set_value(21);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_seg", 16'(seg_pair()), 16'(ZERO_PAIR));
        check_eq("midrst_busy", 16'(bus.o_busy), 16'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        shown = ZERO_PAIR;
        wait_result("v21_after_rst", 1'b0, bc);
        check_eq("v21_busy", 16'(bc), 16'd7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
